// File: rtl/ex_div_if.sv
// Execute-stage divider bus: operand delivery from the decode/execute register,
// stall request back to pipeline control, and the result returned to the
// execute-stage result mux.
//
// Handshake: the execute stage raises start_i for a divide op; the divider
// accepts it only while idle and not flushed, and holds stallreq_o high from the
// acceptance cycle until the result cycle. ready_o (with wreg_o) is a single-cycle
// pulse that marks result_o/wd_o valid; stallreq_o is low in that same cycle so
// the pipeline advances exactly as the result is presented. flush_i aborts
// everything and suppresses the pulse.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [1:0]        op_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
    logic [4:0]        wd_i;
    logic              flush_i;
    logic              stallreq_o;
    logic              ready_o;
    logic [DATA_W-1:0] result_o;
    logic [4:0]        wd_o;
    logic              wreg_o;

    // Pipeline side: drives the operation, receives stall and result.
    modport master (
        output start_i, op_i, dividend_i, divisor_i, wd_i, flush_i,
        input  stallreq_o, ready_o, result_o, wd_o, wreg_o
    );

    // Divider side.
    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, wd_i, flush_i,
        output stallreq_o, ready_o, result_o, wd_o, wreg_o
    );
endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Magnitudes are divided unsigned, one quotient bit per cycle MSB first, and the
// signs are reapplied when the result is registered. Divide-by-zero skips the
// iteration and returns its architectural result one cycle after acceptance.
module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    ex_div_if.slave    bus,
    output logic [1:0] dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Partial remainder (upper DATA_W+1 bits) concatenated with the dividend /
    // quotient being shifted in from the bottom.
    localparam int ACC_W = 2 * DATA_W + 1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic              is_rem_q, is_rem_d;
    logic [4:0]        wd_q, wd_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic              ready_q, ready_d;
    logic              wreg_q, wreg_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [4:0]        wd_out_q, wd_out_d;
    logic              stallreq_c;

    // Operand conditioning at acceptance: signed ops divide magnitudes.
    logic              is_signed;
    logic              dividend_neg;
    logic              divisor_neg;
    logic [DATA_W-1:0] abs_dividend;
    logic [DATA_W-1:0] abs_divisor;
    logic [DATA_W-1:0] zero_div_result;

    always_comb begin
        is_signed       = ~bus.op_i[0];
        dividend_neg    = is_signed & bus.dividend_i[DATA_W-1];
        divisor_neg     = is_signed & bus.divisor_i[DATA_W-1];
        abs_dividend    = dividend_neg ? -bus.dividend_i : bus.dividend_i;
        abs_divisor     = divisor_neg  ? -bus.divisor_i  : bus.divisor_i;
        zero_div_result = bus.op_i[1] ? bus.dividend_i : {DATA_W{1'b1}};
    end

    // One restoring shift-subtract step and the sign-fixed final result.
    logic [ACC_W-1:0]  shifted;
    logic [DATA_W:0]   upper;
    logic [DATA_W:0]   trial;
    logic              fits;
    logic [ACC_W-1:0]  step;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] calc_result;

    always_comb begin
        shifted = {acc_q[ACC_W-2:0], 1'b0};
        upper   = shifted[ACC_W-1:DATA_W];
        trial   = upper - {1'b0, divisor_q};
        // The top accumulator bit is always clear after a step because the
        // remainder stays below the divisor; a set bit would mean "fits".
        fits    = acc_q[ACC_W-1] | (upper >= {1'b0, divisor_q});
        step    = fits ? {trial, shifted[DATA_W-1:1], 1'b1} : shifted;
        quot    = step[DATA_W-1:0];
        rem     = step[2*DATA_W-1:DATA_W];
        if (is_rem_q) begin
            calc_result = neg_rem_q ? -rem : rem;
        end else begin
            calc_result = neg_quot_q ? -quot : quot;
        end
    end

    // Next-state, operand latching, iteration and result registration.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        divisor_d  = divisor_q;
        is_rem_d   = is_rem_q;
        wd_d       = wd_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = 1'b0;
        wreg_d     = 1'b0;
        result_d   = result_q;
        wd_out_d   = wd_out_q;
        stallreq_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    stallreq_c = 1'b1;
                    is_rem_d   = bus.op_i[1];
                    wd_d       = bus.wd_i;
                    divisor_d  = abs_divisor;
                    neg_quot_d = dividend_neg ^ divisor_neg;
                    neg_rem_d  = dividend_neg;
                    cnt_d      = '0;
                    acc_d      = {{(DATA_W+1){1'b0}}, abs_dividend};
                    if (bus.divisor_i == '0) begin
                        state_d  = S_DONE;
                        ready_d  = 1'b1;
                        wreg_d   = 1'b1;
                        result_d = zero_div_result;
                        wd_out_d = bus.wd_i;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    stallreq_c = 1'b1;
                    acc_d      = step;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d  = S_DONE;
                        ready_d  = 1'b1;
                        wreg_d   = 1'b1;
                        result_d = calc_result;
                        wd_out_d = wd_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            divisor_q  <= '0;
            is_rem_q   <= 1'b0;
            wd_q       <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= 1'b0;
            wreg_q     <= 1'b0;
            result_q   <= '0;
            wd_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            divisor_q  <= divisor_d;
            is_rem_q   <= is_rem_d;
            wd_q       <= wd_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ready_q    <= ready_d;
            wreg_q     <= wreg_d;
            result_q   <= result_d;
            wd_out_q   <= wd_out_d;
        end
    end

    assign bus.stallreq_o = stallreq_c;
    assign bus.ready_o    = ready_q;
    assign bus.wreg_o     = wreg_q;
    assign bus.result_o   = result_q;
    assign bus.wd_o       = wd_out_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed RV32M corner cases, randomized
// operations against an arithmetic reference model, flush, mid-op reset and
// back-to-back issue.
module tb_ex_div;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    ex_div_if #(.DATA_W(32)) bus();

    ex_div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    // Architectural RV32M result computed with wide signed arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic drive_idle();
        bus.start_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.op_i       = 2'b00;
        bus.dividend_i = 32'd0;
        bus.divisor_i  = 32'd0;
        bus.wd_i       = 5'd0;
    endtask

    // Issue one op at the current negedge and follow it to its result pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input bit scramble, input string name);
        int          lat;
        bit          got;
        bit          stall_bad;
        logic [31:0] want;
        exp_q.push_back(ref_div(op, a, b));
        lat = (b == 32'd0) ? 1 : 33;
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.wd_i       = wd;
        #1;
        checks++;
        if (bus.stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL %s stall_accept got %b want 1", name, bus.stallreq_o);
        end
        got = 0;
        stall_bad = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
            if (scramble) begin
                bus.dividend_i = $urandom();
                bus.divisor_i  = $urandom();
                bus.op_i       = 2'($urandom_range(0, 3));
                bus.wd_i       = 5'($urandom_range(0, 31));
            end
            #1;
            if (bus.ready_o === 1'b1) begin
                got = 1;
                want = exp_q.pop_front();
                checks++;
                if (i != lat) begin
                    errors++;
                    $display("FAIL %s latency got %0d want %0d", name, i, lat);
                end
                checks++;
                if (bus.result_o !== want) begin
                    errors++;
                    $display("FAIL %s result got %h want %h", name, bus.result_o, want);
                end
                checks++;
                if (bus.wd_o !== wd || bus.wreg_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s wd_wreg got %0d/%b want %0d/1", name, bus.wd_o, bus.wreg_o, wd);
                end
                if (bus.stallreq_o !== 1'b0) stall_bad = 1;
            end else if (bus.stallreq_o !== logic'(i < lat)) begin
                stall_bad = 1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            void'(exp_q.pop_front());
            $display("FAIL %s timeout no ready within 40 cycles", name);
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL %s stall_profile got wrong stallreq_o want high until result", name);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.wreg_o !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width got ready %b wreg %b want 0 0", name, bus.ready_o, bus.wreg_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.wreg_o !== 1'b0 || bus.result_o !== 32'd0 ||
            bus.wd_o !== 5'd0 || bus.stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got rdy %b wreg %b res %h wd %0d stall %b want all zero",
                     bus.ready_o, bus.wreg_o, bus.result_o, bus.wd_o, bus.stallreq_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(2'b01, 32'd100, 32'd7, 5'd5, 0, "divu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "rem_m7_2");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, "div_m7_2");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, "div_overflow");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, "rem_overflow");
        run_op(2'b01, 32'h0000_1234, 32'd0, 5'd10, 0, "divu_by_zero");
        run_op(2'b11, 32'h0000_1234, 32'd0, 5'd11, 0, "remu_by_zero");
        run_op(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd12, 0, "div_neg_by_zero");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd13, 0, "rem_neg_by_zero");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 5'd14, 0, "remu_large");
        run_op(2'b01, 32'd100, 32'd7, 5'd15, 1, "divu_operand_change");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int n = 0; n < 16; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom();
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(op, a, b, 5'($urandom_range(0, 31)), 1, "random");
        end
    endtask

    task automatic test_flush();
        int          ready_at[$];
        logic [31:0] res_at[$];
        logic [4:0]  wd_at[$];
        for (int k = 0; k <= 50; k++) begin
            case (k)
                0: begin
                    bus.start_i = 1'b1; bus.op_i = 2'b01;
                    bus.dividend_i = 32'd100; bus.divisor_i = 32'd7; bus.wd_i = 5'd5;
                end
                1:  bus.start_i = 1'b0;
                10: bus.flush_i = 1'b1;
                11: bus.flush_i = 1'b0;
                12: begin
                    bus.start_i = 1'b1; bus.op_i = 2'b01;
                    bus.dividend_i = 32'd9; bus.divisor_i = 32'd3; bus.wd_i = 5'd9;
                end
                13: bus.start_i = 1'b0;
                default: ;
            endcase
            #1;
            if (k == 10) begin
                checks++;
                if (bus.stallreq_o !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_stall got %b want 0", bus.stallreq_o);
                end
            end
            if (k == 12) begin
                checks++;
                if (bus.stallreq_o !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_restart_stall got %b want 1", bus.stallreq_o);
                end
            end
            if (bus.ready_o === 1'b1) begin
                ready_at.push_back(k);
                res_at.push_back(bus.result_o);
                wd_at.push_back(bus.wd_o);
            end
            @(negedge clk);
        end
        checks++;
        if (ready_at.size() != 1) begin
            errors++;
            $display("FAIL flush_pulse_count got %0d want 1", ready_at.size());
        end else begin
            checks++;
            if (ready_at[0] != 45 || res_at[0] !== 32'd3 || wd_at[0] !== 5'd9) begin
                errors++;
                $display("FAIL flush_restart got cycle %0d res %h wd %0d want 45 3 9",
                         ready_at[0], res_at[0], wd_at[0]);
            end
        end
        drive_idle();
    endtask

    task automatic test_flush_start_idle();
        int pulses = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k == 0) begin
                bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'b01;
                bus.dividend_i = 32'd50; bus.divisor_i = 32'd5; bus.wd_i = 5'd3;
            end else if (k == 1) begin
                drive_idle();
            end
            #1;
            if (k == 0) begin
                checks++;
                if (bus.stallreq_o !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_start_stall got %b want 0", bus.stallreq_o);
                end
            end
            if (k == 1) begin
                checks++;
                if (bus.stallreq_o !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_start_not_accepted got stall %b want 0", bus.stallreq_o);
                end
            end
            if (bus.ready_o === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL flush_start_pulses got %0d want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int k = 0; k <= 45; k++) begin
            case (k)
                0: begin
                    bus.start_i = 1'b1; bus.op_i = 2'b01;
                    bus.dividend_i = 32'd100; bus.divisor_i = 32'd7; bus.wd_i = 5'd5;
                end
                1: bus.start_i = 1'b0;
                5: rst = 1'b1;
                6: rst = 1'b0;
                default: ;
            endcase
            #1;
            if (k == 6) begin
                checks++;
                if (bus.ready_o !== 1'b0 || bus.wreg_o !== 1'b0 || bus.result_o !== 32'd0 ||
                    bus.wd_o !== 5'd0 || bus.stallreq_o !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_values got rdy %b wreg %b res %h wd %0d stall %b want zeros",
                             bus.ready_o, bus.wreg_o, bus.result_o, bus.wd_o, bus.stallreq_o);
                end
            end
            if (bus.ready_o === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset_pulses got %0d want 0", pulses);
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        int          ready_at[$];
        logic [31:0] res_at[$];
        bit          stall_bad = 0;
        for (int k = 0; k <= 75; k++) begin
            if (k == 0) begin
                bus.start_i = 1'b1; bus.op_i = 2'b01;
                bus.dividend_i = 32'd1000; bus.divisor_i = 32'd10; bus.wd_i = 5'd3;
            end else if (k == 70) begin
                bus.start_i = 1'b0;
            end
            #1;
            if (bus.ready_o === 1'b1) begin
                ready_at.push_back(k);
                res_at.push_back(bus.result_o);
                if (bus.stallreq_o !== 1'b0) stall_bad = 1;
            end
            if (k == 34 && bus.stallreq_o !== 1'b1) stall_bad = 1;
            @(negedge clk);
        end
        checks++;
        if (ready_at.size() != 2) begin
            errors++;
            $display("FAIL b2b_pulse_count got %0d want 2", ready_at.size());
        end else begin
            checks++;
            if (ready_at[0] != 33 || ready_at[1] != 67) begin
                errors++;
                $display("FAIL b2b_spacing got %0d,%0d want 33,67", ready_at[0], ready_at[1]);
            end
            checks++;
            if (res_at[0] !== 32'd100 || res_at[1] !== 32'd100) begin
                errors++;
                $display("FAIL b2b_result got %h,%h want 64,64", res_at[0], res_at[1]);
            end
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL b2b_stall got wrong stallreq_o want 0 in result cycle, 1 on reaccept");
        end
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_flush_start_idle();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before 500us");
        $fatal(1, "watchdog");
    end

endmodule
